// File: rtl/aes_seq_pkg.sv
// Shared types and helpers for the AES job sequencer: FSM states, register
// map bases and 128-bit block word access (word 0 is the most significant).
package aes_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [2:0] KEY_BASE = 3'd0;
  localparam logic [2:0] TXT_BASE = 3'd4;

  typedef logic [127:0] blk128_t;

  // Word idx sits at bit offset (3-idx)*32; for a 2-bit idx, 3-idx == ~idx.
  function automatic blk128_t put_word(blk128_t blk, logic [1:0] idx, logic [31:0] w);
    blk128_t r;
    r = blk;
    r[{~idx, 5'd0} +: 32] = w;
    return r;
  endfunction

  function automatic logic [31:0] get_word(blk128_t blk, logic [1:0] idx);
    return blk[{~idx, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/aes_seq_watchdog.sv
// RUN-phase watchdog: cleared on LOAD, counts while enabled, saturates at
// all-ones, and flags expiry on the cycle the count reaches TIMEOUT-1.
module aes_seq_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                       cnt <= '0;
    else if (clear)                   cnt <= '0;
    else if (enable && (cnt != '1))   cnt <= cnt + 1'b1;
  end

  assign expire = enable && (cnt == LIMIT);

endmodule

// File: rtl/aes_job_sequencer.sv
// Sequences one AES-128 block job: collects key/text words from register
// writes, loads the core, waits for done under a watchdog, latches the result.
module aes_job_sequencer
  import aes_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              mode,
  input  logic              clr,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              irq,
  output logic [127:0]      core_key,
  output logic [127:0]      core_din,
  output logic              core_mode,
  output logic              core_load,
  input  logic              core_done,
  input  logic [127:0]      core_dout
);

  state_t  state, state_nx;
  blk128_t key_q, txt_q, res_q;
  logic    mode_q, done_q, err_q, irq_q;
  logic    in_idle, in_run, expire, finish, tmo, txt_sel;

  assign in_idle = (state == IDLE);
  assign in_run  = (state == RUN);
  assign finish  = in_run && core_done;
  // A completion on the expiry cycle takes priority over the timeout.
  assign tmo     = expire && !core_done;
  assign txt_sel = (wr_addr[2] == TXT_BASE[2]);

  aes_seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .clear  (state == LOAD),
    .enable (in_run),
    .expire (expire)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (core_done || expire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      key_q  <= '0;
      txt_q  <= '0;
      res_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irq_q <= finish || tmo;

      // Key/text regs only change in IDLE, so they stay stable to the core.
      if (in_idle && wr_en) begin
        if (txt_sel) txt_q <= put_word(txt_q, wr_addr[1:0], wr_data);
        else         key_q <= put_word(key_q, wr_addr[1:0], wr_data);
      end

      if (in_idle && start) mode_q <= mode;

      if (finish)                        begin res_q <= core_dout; done_q <= 1'b1; end
      else if (in_idle && (start || clr)) done_q <= 1'b0;

      if (tmo || (!in_idle && wr_en))    err_q <= 1'b1;
      else if (clr || (in_idle && start)) err_q <= 1'b0;
    end
  end

  assign rd_data   = get_word(res_q, rd_addr);
  assign busy      = !in_idle;
  assign done      = done_q;
  assign err       = err_q;
  assign irq       = irq_q;
  assign core_key  = key_q;
  assign core_din  = txt_q;
  assign core_mode = mode_q;
  assign core_load = (state == LOAD);

endmodule
